// File: rtl/tdm_demux8.sv
// Receiving end of an 8:1 TDM serial link: frame-synchronised slot counter
// that assembles eight serial bits into a parallel byte with a valid strobe.
module tdm_demux8 #(
  parameter bit INV_IN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En_n,
  input  logic       sync,
  input  logic       din,
  output logic [2:0] S,
  output logic [7:0] Q,
  output logic [7:0] Qn,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned SLOT_W  = 3;
  localparam int unsigned FRAME_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [SLOT_W-1:0]   cnt;
  logic [FRAME_W-1:0]  acc;
  logic                b_c;

  assign b_c = din ^ INV_IN;

  // cnt is forced to 0 whenever the block is idle, so it doubles as the select.
  assign S = cnt;

  // In RUN, cnt==0 marks the cycle after slot 7: the frame is published and a
  // sync arriving in that cycle starts the next frame without an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      Q         <= '0;
      Qn        <= '1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (En_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (sync) begin
              acc   <= FRAME_W'(b_c);
              cnt   <= SLOT_W'(1);
              state <= RUN;
            end else begin
              cnt <= '0;
            end
          end
          RUN: begin
            if (cnt == '0) begin
              Q     <= acc;
              Qn    <= ~acc;
              valid <= 1'b1;
              if (sync) begin
                acc <= FRAME_W'(b_c);
                cnt <= SLOT_W'(1);
              end else begin
                state <= IDLE;
              end
            end else if (sync) begin
              frame_err <= 1'b1;
              acc       <= FRAME_W'(b_c);
              cnt       <= SLOT_W'(1);
            end else begin
              acc[cnt] <= b_c;
              cnt      <= cnt + SLOT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomised and directed bench for tdm_demux8 with a frame-level reference model.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_n;
  logic       sync;
  logic       din;
  logic [2:0] s0, s1;
  logic [7:0] q0, q1, qn0, qn1;
  logic       valid0, valid1, err0, err1;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position (-1 idle, 1..8 bits collected) and byte value.
  int         m_pos;
  logic [7:0] m_val;
  logic [7:0] m_q;
  logic [7:0] m_q1;
  logic       m_valid;
  logic       m_err;

  tdm_demux8 #(.INV_IN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .En_n(en_n), .sync(sync), .din(din),
    .S(s0), .Q(q0), .Qn(qn0), .valid(valid0), .frame_err(err0)
  );

  tdm_demux8 #(.INV_IN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .En_n(en_n), .sync(sync), .din(din),
    .S(s1), .Q(q1), .Qn(qn1), .valid(valid1), .frame_err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_val = '0; m_q = '0; m_q1 = '0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(input logic e, input logic sy, input logic d);
    m_valid = 0;
    m_err   = 0;
    if (e) begin
      m_pos = -1;
    end else if (m_pos == 8) begin
      m_q     = m_val;
      m_q1    = ~m_val;
      m_valid = 1;
      if (sy) begin m_val = 8'(d); m_pos = 1; end
      else m_pos = -1;
    end else if (sy) begin
      if (m_pos >= 1) m_err = 1;
      m_val = 8'(d);
      m_pos = 1;
    end else if (m_pos >= 1) begin
      m_val = m_val | (8'(d) << m_pos);
      m_pos++;
    end
  endtask

  function automatic logic [7:0] exp_s();
    return (m_pos >= 1 && m_pos <= 7) ? 8'(m_pos) : 8'h00;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".S"},      8'(s0),     exp_s());
    chk({tag, ".Q"},      q0,         m_q);
    chk({tag, ".Qn"},     qn0,        ~m_q);
    chk({tag, ".valid"},  8'(valid0), 8'(m_valid));
    chk({tag, ".err"},    8'(err0),   8'(m_err));
    chk({tag, ".inv.Q"},  q1,         m_q1);
    chk({tag, ".inv.Qn"}, qn1,        ~m_q1);
    chk({tag, ".inv.S"},  8'(s1),     exp_s());
  endtask

  task automatic step(input string tag, input logic e, input logic sy, input logic d);
    en_n = e; sync = sy; din = d;
    @(posedge clk);
    model_step(e, sy, d);
    #1;
    check_all(tag);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] v);
    for (int k = 0; k < 8; k++) step(tag, 1'b0, k == 0, v[k]);
  endtask

  initial begin
    rst_n = 1'b0; en_n = 1'b1; sync = 1'b0; din = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled link ignores sync
    for (int i = 0; i < 4; i++) step("disabled", 1'b1, i[0], 1'b1);

    // Single frame 0x55 (inverting instance sees 0xAA)
    send_frame("f55", 8'h55);
    step("f55.pub", 1'b0, 1'b0, 1'b0);
    step("f55.idle", 1'b0, 1'b0, 1'b1);

    // All-ones frame: inverting instance must give Q=00, Qn=FF
    send_frame("ones", 8'hFF);
    step("ones.pub", 1'b0, 1'b0, 1'b1);

    // Back-to-back frames
    send_frame("b2b.fe", 8'hFE);
    send_frame("b2b.01", 8'h01);
    step("b2b.pub", 1'b0, 1'b0, 1'b0);

    // Resync at slot 4
    for (int k = 0; k < 4; k++) step("resync.part", 1'b0, k == 0, 1'b1);
    send_frame("resync.new", 8'h3C);
    step("resync.pub", 1'b0, 1'b0, 1'b0);

    // Enable removed at slot 3
    for (int k = 0; k < 3; k++) step("abort.part", 1'b0, k == 0, 1'b1);
    step("abort.off", 1'b1, 1'b0, 1'b1);
    step("abort.off2", 1'b1, 1'b0, 1'b1);
    step("abort.idle", 1'b0, 1'b0, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic e, sy, d;
      e  = ($urandom_range(0, 15) == 0);
      sy = ($urandom_range(0, 5) == 0);
      d  = 1'($urandom);
      step("rand", e, sy, d);
    end

    // Randomised well-formed frames, some back-to-back
    for (int i = 0; i < 20; i++) begin
      send_frame("rframe", 8'($urandom));
      if ($urandom_range(0, 1) == 1) step("rframe.gap", 1'b0, 1'b0, 1'($urandom));
    end
    step("rframe.pub", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    send_frame("pre", 8'hA7);
    step("pre.pub", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step("mid.part", 1'b0, k == 0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("midrst.after", 1'b0, 1'b0, 1'b1);
    send_frame("post", 8'h96);
    step("post.pub", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
